regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Shares the single write port of the 16 × 32-bit register file among several writeback sources, e.g. ALU, load unit and CSR/move path. Each cycle it arbitrates round-robin among valid requesters and captures the winner in a one-entry write stage. That stage drives the register file write port one cycle later. It also exports a pending-write mask for decode stall logic and a saturating contention counter for performance monitoring.

## Interface
- NUM_REQ, 3, number of writeback requesters (2..8)
- ADDR_W, 4, register index width (16 registers)
- DATA_W, 32, write data width
- CNT_W, 16, contention counter width
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- req_valid  in  NUM_REQ  per-requester write request
- req_ready  out  NUM_REQ  per-requester grant; one-hot or zero
- req_reg  in  NUM_REQ*ADDR_W  packed target register indices; requester i at [i*ADDR_W +: ADDR_W]
- req_data  in  NUM_REQ*DATA_W  packed write data; requester i at [i*DATA_W +: DATA_W]
- wr_inhibit  in  1  blocks new grants while high
- rf_we  out  1  register file write enable
- rf_wreg  out  ADDR_W  register file write index
- rf_wdata  out  DATA_W  register file write data
- rf_wsrc  out  $clog2(NUM_REQ)  requester id of the staged write (debug)
- pending_mask  out  2**ADDR_W  one-hot of the staged register when rf_we=1, else 0
- conflict_cnt  out  CNT_W  saturating count of cycles with ≥2 valid requests

## Operation
- Handshake: a transfer occurs on a cycle with req_valid[i] & req_ready[i].
- Once raised, req_valid[i], req_reg and req_data must stay stable until the transfer. The bench flags any violation.
- Grant is combinational from req_valid, the rotation pointer ptr and wr_inhibit.
  - The winner is the first i with req_valid[i]=1, scanning ptr, ptr+1, … mod NUM_REQ.
  - req_ready is 0 when there is no valid request or wr_inhibit=1.
- On a transfer by requester w:
  - ptr ← (w+1) mod NUM_REQ.
  - The stage loads {valid=1, reg, data, src=w}.
- With no transfer, ptr is unchanged and stage valid ← 0.
- The register file accepts every write, so the stage never back-pressures. One grant is possible every cycle.
- Same-register requests from different sources in one cycle: only the winner is granted. The others write in later cycles in grant order, so the last-granted value persists.
- Register 0 has no special meaning; every index is writable.
- conflict_cnt increments on each cycle with popcount(req_valid) ≥ 2, whether or not wr_inhibit is set. It saturates at 2**CNT_W−1 and is cleared only by reset.

## Timing
- Latency: transfer in cycle N; rf_we/rf_wreg/rf_wdata are valid during cycle N+1. The register file commits at the clk edge ending N+1.
- pending_mask is registered and aligned with rf_we.
- Reset values:
  - rf_we=0, rf_wreg=0, rf_wdata=0, rf_wsrc=0, pending_mask=0.
  - conflict_cnt=0, ptr=0.
  - req_ready=0 while reset is asserted.
- Reset mid-operation: the staged write is discarded and never reaches the register file. Requesters keep req_valid and are re-arbitrated from ptr=0 after reset deasserts.
- wr_inhibit rising in cycle N: no grant in N. A write staged in N−1 still completes in N.
- Pointer wrap: a grant to NUM_REQ−1 sets ptr=0.
- A single continuously valid requester is granted every cycle.
- With all requesters continuously valid, each is granted exactly once per NUM_REQ cycles.

## Structure
- Shared package regfile_pkg holds:
  - REG_ADDR_W=4, REG_DATA_W=32, NUM_REGS=16.
  - The requester-id localparams (WB_ALU=0, WB_LOAD=1, WB_MISC=2), also used by the register file and decode.
- Sub-module rr_arbiter (parameter N):
  - Inputs: req, enable.
  - Outputs: one-hot grant and encoded grant_id.
  - Owns ptr internally; ptr updates only when a grant is issued.
- Top level holds the data mux, write stage, pending_mask decode and conflict counter.

## Test plan
- Single requester: req_valid=3'b001, reg=5, data=32'hDEADBEEF → req_ready=3'b001 in cycle N; rf_we=1, rf_wreg=5, rf_wdata=DEADBEEF, pending_mask=16'h0020 in N+1.
- Fairness: all three valid continuously for 6 cycles from reset → grant sequence 0,1,2,0,1,2. conflict_cnt=6.
- Collision: requester 0 (reg 3, data 1) and requester 2 (reg 3, data 2) valid together with ptr=0 → requester 0 written first, requester 2 next cycle. Register 3 ends at 2.
- Inhibit: wr_inhibit=1 for 4 cycles with 3'b011 valid → req_ready=0 and rf_we=0 after the in-flight write. After release, requester at ptr is granted first.
- Reset mid-write: assert reset in the cycle after a transfer → rf_we=0 immediately, no commit. After deassert, ptr=0 and the still-valid requester is regranted.
- Saturation: CNT_W=4, two requesters valid for 20 cycles → conflict_cnt stops at 15.

Source files
------------

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared register-file constants and writeback source identifiers used by
// the write arbiter, the register file and decode.
package regfile_pkg;

    localparam int REG_ADDR_W = 4;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 16;

    // Requester ids; the arbiter port index equals the id.
    localparam int WB_ALU     = 0;
    localparam int WB_LOAD    = 1;
    localparam int WB_MISC    = 2;
    localparam int NUM_WB_SRC = 3;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback request bus: one valid/ready pair per requester plus packed
// target register indices and write data.
interface regfile_write_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*ADDR_W-1:0] req_reg;
    logic [NUM_REQ*DATA_W-1:0] req_data;

    modport master (
        output req_valid,
        output req_reg,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_reg,
        input  req_data,
        output req_ready
    );
endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant scanning from ptr, with
// ptr advancing past the winner only on cycles that actually grant.
module rr_arbiter #(
    parameter int N = 3,
    localparam int ID_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req,
    input  logic            enable,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] grant_id
);

    logic [ID_W-1:0] ptr_q;
    logic [ID_W-1:0] ptr_d;
    logic            found;
    int              idx;

    always_comb begin
        found    = 1'b0;
        grant_id = '0;
        idx      = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[idx]) begin
                found    = 1'b1;
                grant_id = idx[ID_W-1:0];
            end
        end
        if (!enable) begin
            found = 1'b0;
        end

        grant = '0;
        ptr_d = ptr_q;
        if (found) begin
            grant[grant_id] = 1'b1;
            // Explicit wrap keeps ptr inside 0..N-1 for non-power-of-two N.
            ptr_d = (grant_id == ID_W'(N - 1)) ? '0 : grant_id + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates writeback sources onto the single register-file write port
// through a one-entry write stage; exports pending mask and contention count.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = NUM_WB_SRC,
    parameter int ADDR_W  = REG_ADDR_W,
    parameter int DATA_W  = REG_DATA_W,
    parameter int CNT_W   = 16,
    localparam int SRC_W  = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    reset,
    regfile_write_arbiter_if.slave  req_if,
    input  logic                    wr_inhibit,
    output logic                    rf_we,
    output logic [ADDR_W-1:0]       rf_wreg,
    output logic [DATA_W-1:0]       rf_wdata,
    output logic [SRC_W-1:0]        rf_wsrc,
    output logic [2**ADDR_W-1:0]    pending_mask,
    output logic [CNT_W-1:0]        conflict_cnt
);

    logic [NUM_REQ-1:0]   grant;
    logic [SRC_W-1:0]     grant_id;
    logic                 transfer;
    logic [ADDR_W-1:0]    sel_reg;
    logic [DATA_W-1:0]    sel_data;
    logic                 multi_valid;
    int                   n_valid;

    logic                 we_q;
    logic [ADDR_W-1:0]    wreg_q;
    logic [DATA_W-1:0]    wdata_q;
    logic [SRC_W-1:0]     wsrc_q;
    logic [2**ADDR_W-1:0] pend_q;
    logic [2**ADDR_W-1:0] pend_d;
    logic [CNT_W-1:0]     cnt_q;

    // Reset gates the enable so nothing is granted while reset is held.
    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk      (clk),
        .reset    (reset),
        .req      (req_if.req_valid),
        .enable   (!wr_inhibit && !reset),
        .grant    (grant),
        .grant_id (grant_id)
    );

    assign req_if.req_ready = grant;
    assign transfer         = |grant;

    always_comb begin
        sel_reg  = '0;
        sel_data = '0;
        n_valid  = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_reg  = req_if.req_reg[i*ADDR_W +: ADDR_W];
                sel_data = req_if.req_data[i*DATA_W +: DATA_W];
            end
            if (req_if.req_valid[i]) begin
                n_valid = n_valid + 1;
            end
        end
        multi_valid = (n_valid >= 2);
    end

    for (genvar gi = 0; gi < 2**ADDR_W; gi++) begin : g_pend
        assign pend_d[gi] = transfer && (sel_reg == ADDR_W'(gi));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q    <= 1'b0;
            wreg_q  <= '0;
            wdata_q <= '0;
            wsrc_q  <= '0;
            pend_q  <= '0;
        end else begin
            we_q   <= transfer;
            pend_q <= pend_d;
            if (transfer) begin
                wreg_q  <= sel_reg;
                wdata_q <= sel_data;
                wsrc_q  <= grant_id;
            end
        end
    end

    // Counts contention regardless of inhibit; sticks at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (multi_valid && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign rf_we        = we_q;
    assign rf_wreg      = wreg_q;
    assign rf_wdata     = wdata_q;
    assign rf_wsrc      = wsrc_q;
    assign pending_mask = pend_q;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: a default-width instance plus a
// CNT_W=4 instance sharing the same stimulus for counter saturation.
module tb_regfile_write_arbiter;
    import regfile_pkg::*;

    logic        clk;
    logic        reset;
    logic        wr_inhibit;
    logic        rf_we,   s_rf_we;
    logic [3:0]  rf_wreg, s_rf_wreg;
    logic [31:0] rf_wdata, s_rf_wdata;
    logic [1:0]  rf_wsrc, s_rf_wsrc;
    logic [15:0] pending_mask, s_pending_mask;
    logic [15:0] conflict_cnt;
    logic [3:0]  s_conflict_cnt;

    int checks;
    int failures;

    regfile_write_arbiter_if #(.NUM_REQ(3), .ADDR_W(4), .DATA_W(32)) bus ();
    regfile_write_arbiter_if #(.NUM_REQ(3), .ADDR_W(4), .DATA_W(32)) sat_bus ();

    assign sat_bus.req_valid = bus.req_valid;
    assign sat_bus.req_reg   = bus.req_reg;
    assign sat_bus.req_data  = bus.req_data;

    regfile_write_arbiter #(.NUM_REQ(3), .ADDR_W(4), .DATA_W(32), .CNT_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_if       (bus),
        .wr_inhibit   (wr_inhibit),
        .rf_we        (rf_we),
        .rf_wreg      (rf_wreg),
        .rf_wdata     (rf_wdata),
        .rf_wsrc      (rf_wsrc),
        .pending_mask (pending_mask),
        .conflict_cnt (conflict_cnt)
    );

    regfile_write_arbiter #(.NUM_REQ(3), .ADDR_W(4), .DATA_W(32), .CNT_W(4)) u_sat (
        .clk          (clk),
        .reset        (reset),
        .req_if       (sat_bus),
        .wr_inhibit   (wr_inhibit),
        .rf_we        (s_rf_we),
        .rf_wreg      (s_rf_wreg),
        .rf_wdata     (s_rf_wdata),
        .rf_wsrc      (s_rf_wsrc),
        .pending_mask (s_pending_mask),
        .conflict_cnt (s_conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [3:0] r, input logic [31:0] d);
        bus.req_reg[i*4 +: 4]   = r;
        bus.req_data[i*32 +: 32] = d;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        reset      = 1'b1;
        wr_inhibit = 1'b0;
        bus.req_valid = '0;
        bus.req_reg   = '0;
        bus.req_data  = '0;

        // Reset state
        tick();
        tick();
        check("reset_rf_we", 64'(rf_we), 64'd0);
        check("reset_rf_wreg", 64'(rf_wreg), 64'd0);
        check("reset_rf_wdata", 64'(rf_wdata), 64'd0);
        check("reset_rf_wsrc", 64'(rf_wsrc), 64'd0);
        check("reset_pending", 64'(pending_mask), 64'd0);
        check("reset_cnt", 64'(conflict_cnt), 64'd0);
        bus.req_valid = 3'b111;
        #1;
        check("reset_ready", 64'(bus.req_ready), 64'd0);
        bus.req_valid = 3'b000;
        reset = 1'b0;
        #1;
        $display("txn reset: done");

        // Single requester
        set_req(WB_ALU, 4'd5, 32'hDEADBEEF);
        bus.req_valid = 3'b001;
        #1;
        check("single_ready", 64'(bus.req_ready), 64'h1);
        tick();
        bus.req_valid = 3'b000;
        check("single_we", 64'(rf_we), 64'd1);
        check("single_wreg", 64'(rf_wreg), 64'd5);
        check("single_wdata", 64'(rf_wdata), 64'hDEADBEEF);
        check("single_wsrc", 64'(rf_wsrc), 64'd0);
        check("single_pending", 64'(pending_mask), 64'h0020);
        tick();
        check("single_idle_we", 64'(rf_we), 64'd0);
        check("single_idle_pending", 64'(pending_mask), 64'd0);
        $display("txn single: reg=5 data=deadbeef");

        // Fairness from reset, including pointer wrap
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_req(0, 4'd1, 32'h10);
        set_req(1, 4'd2, 32'h20);
        set_req(2, 4'd3, 32'h30);
        bus.req_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            #1;
            check("fair_ready", 64'(bus.req_ready), 64'(3'b001 << (k % 3)));
            tick();
            check("fair_wsrc", 64'(rf_wsrc), 64'(k % 3));
            check("fair_wdata", 64'(rf_wdata), 64'(32'h10 * ((k % 3) + 1)));
            $display("txn fair: cycle=%0d src=%0d", k, k % 3);
        end
        check("fair_cnt", 64'(conflict_cnt), 64'd6);
        bus.req_valid = 3'b000;

        // Same-register collision, ptr=0
        set_req(0, 4'd3, 32'd1);
        set_req(2, 4'd3, 32'd2);
        bus.req_valid = 3'b101;
        #1;
        check("coll_ready0", 64'(bus.req_ready), 64'h1);
        tick();
        bus.req_valid = 3'b100;
        check("coll_first_wdata", 64'(rf_wdata), 64'd1);
        check("coll_first_wsrc", 64'(rf_wsrc), 64'd0);
        #1;
        check("coll_ready2", 64'(bus.req_ready), 64'h4);
        tick();
        bus.req_valid = 3'b000;
        check("coll_second_wreg", 64'(rf_wreg), 64'd3);
        check("coll_second_wdata", 64'(rf_wdata), 64'd2);
        check("coll_second_pending", 64'(pending_mask), 64'h0008);
        check("coll_cnt", 64'(conflict_cnt), 64'd7);
        $display("txn collision: reg3 writes 1 then 2");

        // Inhibit with a write in flight
        set_req(2, 4'd7, 32'h77);
        bus.req_valid = 3'b100;
        #1;
        check("inh_pre_ready", 64'(bus.req_ready), 64'h4);
        tick();
        wr_inhibit = 1'b1;
        set_req(0, 4'd8, 32'h88);
        set_req(1, 4'd9, 32'h99);
        bus.req_valid = 3'b011;
        #1;
        check("inh_ready_first", 64'(bus.req_ready), 64'd0);
        check("inh_inflight_we", 64'(rf_we), 64'd1);
        check("inh_inflight_wdata", 64'(rf_wdata), 64'h77);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("inh_we", 64'(rf_we), 64'd0);
            check("inh_ready", 64'(bus.req_ready), 64'd0);
        end
        tick();
        check("inh_last_we", 64'(rf_we), 64'd0);
        wr_inhibit = 1'b0;
        #1;
        check("inh_release_ready", 64'(bus.req_ready), 64'h1);
        tick();
        bus.req_valid = 3'b010;
        check("inh_release_wsrc", 64'(rf_wsrc), 64'd0);
        check("inh_release_wdata", 64'(rf_wdata), 64'h88);
        #1;
        check("inh_next_ready", 64'(bus.req_ready), 64'h2);
        tick();
        bus.req_valid = 3'b000;
        check("inh_cnt", 64'(conflict_cnt), 64'd12);
        $display("txn inhibit: 4 cycles then src0, src1");

        // Reset mid-write, ptr=2 beforehand
        set_req(0, 4'd10, 32'hA0);
        set_req(1, 4'd11, 32'hB0);
        bus.req_valid = 3'b011;
        #1;
        check("rst_pre_ready", 64'(bus.req_ready), 64'h1);
        tick();
        reset = 1'b1;
        #1;
        check("rst_we", 64'(rf_we), 64'd0);
        check("rst_pending", 64'(pending_mask), 64'd0);
        check("rst_ready", 64'(bus.req_ready), 64'd0);
        check("rst_cnt", 64'(conflict_cnt), 64'd0);
        tick();
        reset = 1'b0;
        #1;
        check("rst_regrant_ready", 64'(bus.req_ready), 64'h1);
        tick();
        check("rst_regrant_wsrc", 64'(rf_wsrc), 64'd0);
        check("rst_regrant_wdata", 64'(rf_wdata), 64'hA0);
        check("rst_regrant_cnt", 64'(conflict_cnt), 64'd1);
        bus.req_valid = 3'b000;
        $display("txn reset_mid: regrant src0");

        // Saturation of the CNT_W=4 instance
        wr_inhibit = 1'b1;
        bus.req_valid = 3'b011;
        for (int k = 0; k < 13; k++) begin
            tick();
        end
        check("sat_pre", 64'(s_conflict_cnt), 64'd14);
        for (int k = 0; k < 7; k++) begin
            tick();
        end
        check("sat_hold", 64'(s_conflict_cnt), 64'd15);
        check("sat_wide_cnt", 64'(conflict_cnt), 64'd21);
        check("sat_inh_we", 64'(rf_we), 64'd0);
        bus.req_valid = 3'b000;
        wr_inhibit = 1'b0;
        $display("txn saturate: cnt4=%0d cnt16=%0d", s_conflict_cnt, conflict_cnt);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
